// File: rtl/sc_gameflow_fsm_if.sv
// sc_gameflow_fsm_if: button/event inputs and playfield control outputs of the game-flow controller
interface sc_gameflow_fsm_if #(
  parameter int LIVES_W = 2,
  parameter int LEVEL_W = 2
);
  logic               SC_GAMEFLOW_startButton_InLow;
  logic               SC_GAMEFLOW_pauseButton_InLow;
  logic               SC_GAMEFLOW_collision_InHigh;
  logic               SC_GAMEFLOW_goal_InHigh;
  logic               SC_GAMEFLOW_clear_OutLow;
  logic               SC_GAMEFLOW_enable_OutHigh;
  logic               SC_GAMEFLOW_respawn_OutHigh;
  logic               SC_GAMEFLOW_gameOver_OutHigh;
  logic               SC_GAMEFLOW_win_OutHigh;
  logic [LIVES_W-1:0] SC_GAMEFLOW_lives_Out;
  logic [LEVEL_W-1:0] SC_GAMEFLOW_level_Out;
  modport slave (
    input  SC_GAMEFLOW_startButton_InLow, SC_GAMEFLOW_pauseButton_InLow,
           SC_GAMEFLOW_collision_InHigh, SC_GAMEFLOW_goal_InHigh,
    output SC_GAMEFLOW_clear_OutLow, SC_GAMEFLOW_enable_OutHigh, SC_GAMEFLOW_respawn_OutHigh,
           SC_GAMEFLOW_gameOver_OutHigh, SC_GAMEFLOW_win_OutHigh,
           SC_GAMEFLOW_lives_Out, SC_GAMEFLOW_level_Out
  );
  modport master (
    output SC_GAMEFLOW_startButton_InLow, SC_GAMEFLOW_pauseButton_InLow,
           SC_GAMEFLOW_collision_InHigh, SC_GAMEFLOW_goal_InHigh,
    input  SC_GAMEFLOW_clear_OutLow, SC_GAMEFLOW_enable_OutHigh, SC_GAMEFLOW_respawn_OutHigh,
           SC_GAMEFLOW_gameOver_OutHigh, SC_GAMEFLOW_win_OutHigh,
           SC_GAMEFLOW_lives_Out, SC_GAMEFLOW_level_Out
  );
endinterface

// File: rtl/sc_gameflow_fsm.sv
// sc_gameflow_fsm: Frogger game-flow controller sequencing play, pause, death, level-up, game-over and win
module sc_gameflow_fsm #(
  parameter int LIVES        = 3,
  parameter int LEVELS       = 4,
  parameter int PAUSE_CYCLES = 50000000,
  parameter int LIVES_W      = $clog2(LIVES + 1),
  parameter int LEVEL_W      = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input logic              SC_GAMEFLOW_CLOCK_50,
  input logic              SC_GAMEFLOW_RESET_InHigh,
  sc_gameflow_fsm_if.slave bus
);
  localparam int TIMER_W = $clog2(PAUSE_CYCLES + 1);
  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_IDLE     = 4'd1,
    S_START    = 4'd2,
    S_PLAY     = 4'd3,
    S_PAUSED   = 4'd4,
    S_HIT      = 4'd5,
    S_LEVELUP  = 4'd6,
    S_GAMEOVER = 4'd7,
    S_WIN      = 4'd8
  } state_t;
  state_t             r_state;
  logic [LIVES_W-1:0] r_lives;
  logic [LEVEL_W-1:0] r_level;
  logic [TIMER_W-1:0] r_timer;
  logic               r_start_prev;
  logic               r_pause_prev;
  logic               w_start_press;
  logic               w_pause_press;
  logic               w_hold_done;
  logic               w_holding;
  assign w_start_press = r_start_prev & ~bus.SC_GAMEFLOW_startButton_InLow;
  assign w_pause_press = r_pause_prev & ~bus.SC_GAMEFLOW_pauseButton_InLow;
  assign w_hold_done   = r_timer == TIMER_W'(PAUSE_CYCLES - 1);
  assign w_holding     = (r_state == S_HIT) || (r_state == S_LEVELUP);
  // Phase sequencing, lives/level bookkeeping, hold timer and button edge history
  always_ff @(posedge SC_GAMEFLOW_CLOCK_50 or posedge SC_GAMEFLOW_RESET_InHigh) begin
    if (SC_GAMEFLOW_RESET_InHigh) begin
      r_state      <= S_RESET;
      r_lives      <= LIVES_W'(LIVES);
      r_level      <= '0;
      r_timer      <= '0;
      r_start_prev <= 1'b1;
      r_pause_prev <= 1'b1;
    end else begin
      r_start_prev <= bus.SC_GAMEFLOW_startButton_InLow;
      r_pause_prev <= bus.SC_GAMEFLOW_pauseButton_InLow;
      case (r_state)
        S_RESET: r_state <= S_IDLE;
        S_IDLE: if (w_start_press) r_state <= S_START;
        S_START: begin
          r_lives <= LIVES_W'(LIVES);
          r_level <= '0;
          r_timer <= '0;
          r_state <= S_PLAY;
        end
        S_PLAY: begin
          if (bus.SC_GAMEFLOW_collision_InHigh) begin
            r_lives <= r_lives - LIVES_W'(1);
            r_state <= (r_lives == LIVES_W'(1)) ? S_GAMEOVER : S_HIT;
          end else if (bus.SC_GAMEFLOW_goal_InHigh) begin
            if (r_level == LEVEL_W'(LEVELS - 1)) r_state <= S_WIN;
            else begin
              r_level <= r_level + LEVEL_W'(1);
              r_state <= S_LEVELUP;
            end
          end else if (w_pause_press) r_state <= S_PAUSED;
        end
        S_PAUSED: if (w_pause_press) r_state <= S_PLAY;
        S_HIT, S_LEVELUP: begin
          r_timer <= w_hold_done ? '0 : r_timer + TIMER_W'(1);
          if (w_hold_done) r_state <= S_PLAY;
        end
        S_GAMEOVER, S_WIN: if (w_start_press) r_state <= S_START;
        default: r_state <= S_RESET;
      endcase
    end
  end
  assign bus.SC_GAMEFLOW_clear_OutLow     = (r_state != S_RESET) && (r_state != S_START);
  assign bus.SC_GAMEFLOW_enable_OutHigh   = r_state == S_PLAY;
  assign bus.SC_GAMEFLOW_respawn_OutHigh  = w_holding && w_hold_done;
  assign bus.SC_GAMEFLOW_gameOver_OutHigh = r_state == S_GAMEOVER;
  assign bus.SC_GAMEFLOW_win_OutHigh      = r_state == S_WIN;
  assign bus.SC_GAMEFLOW_lives_Out        = r_lives;
  assign bus.SC_GAMEFLOW_level_Out        = r_level;
endmodule

// File: tb/tb_sc_gameflow_fsm.sv
// tb_sc_gameflow_fsm: vector table, reset corner case and random run against a phase-level model
module tb_sc_gameflow_fsm;
  localparam int LIVES = 3;
  localparam int LEVELS = 2;
  localparam int PAUSE_CYCLES = 4;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  sc_gameflow_fsm_if #(.LIVES_W(2), .LEVEL_W(1)) bus ();
  sc_gameflow_fsm #(
    .LIVES(LIVES), .LEVELS(LEVELS), .PAUSE_CYCLES(PAUSE_CYCLES), .LIVES_W(2), .LEVEL_W(1)
  ) dut (
    .SC_GAMEFLOW_CLOCK_50(clk),
    .SC_GAMEFLOW_RESET_InHigh(rst),
    .bus(bus.slave)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef enum {P_RST, P_IDLE, P_START, P_PLAY, P_PAUSE, P_HOLD, P_OVER, P_WIN} phase_t;
  phase_t m_phase;
  int     m_lives;
  int     m_level;
  int     m_left;
  bit     m_sprev;
  bit     m_pprev;
  typedef struct {
    bit         st;
    bit         pa;
    bit         co;
    bit         go;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [7:0] mk_out(bit cl, bit en, bit rs, bit gv, bit wn, int lv, int lvl);
    logic [1:0] l2;
    logic       l1;
    l2 = 2'(lv);
    l1 = 1'(lvl);
    return {cl, en, rs, gv, wn, l2, l1};
  endfunction
  function automatic vec_t mk(bit st, bit pa, bit co, bit go, bit cl, bit en, bit rs, bit gv, bit wn, int lv, int lvl);
    vec_t v;
    v.st = st; v.pa = pa; v.co = co; v.go = go;
    v.exp = mk_out(cl, en, rs, gv, wn, lv, lvl);
    return v;
  endfunction
  function automatic logic [7:0] dut_vec();
    return {bus.SC_GAMEFLOW_clear_OutLow, bus.SC_GAMEFLOW_enable_OutHigh, bus.SC_GAMEFLOW_respawn_OutHigh,
            bus.SC_GAMEFLOW_gameOver_OutHigh, bus.SC_GAMEFLOW_win_OutHigh,
            bus.SC_GAMEFLOW_lives_Out, bus.SC_GAMEFLOW_level_Out};
  endfunction
  function automatic void model_reset();
    m_phase = P_RST; m_lives = LIVES; m_level = 0; m_left = 0; m_sprev = 1; m_pprev = 1;
  endfunction
  function automatic void model_edge();
    bit sp;
    bit pp;
    sp = m_sprev && !bus.SC_GAMEFLOW_startButton_InLow;
    pp = m_pprev && !bus.SC_GAMEFLOW_pauseButton_InLow;
    m_sprev = bus.SC_GAMEFLOW_startButton_InLow;
    m_pprev = bus.SC_GAMEFLOW_pauseButton_InLow;
    case (m_phase)
      P_RST: m_phase = P_IDLE;
      P_IDLE, P_OVER, P_WIN: if (sp) m_phase = P_START;
      P_START: begin m_lives = LIVES; m_level = 0; m_phase = P_PLAY; end
      P_PLAY:
        if (bus.SC_GAMEFLOW_collision_InHigh) begin
          m_lives--;
          if (m_lives == 0) m_phase = P_OVER;
          else begin m_phase = P_HOLD; m_left = PAUSE_CYCLES; end
        end else if (bus.SC_GAMEFLOW_goal_InHigh) begin
          if (m_level == LEVELS - 1) m_phase = P_WIN;
          else begin m_level++; m_phase = P_HOLD; m_left = PAUSE_CYCLES; end
        end else if (pp) m_phase = P_PAUSE;
      P_PAUSE: if (pp) m_phase = P_PLAY;
      P_HOLD: begin m_left--; if (m_left == 0) m_phase = P_PLAY; end
      default: m_phase = P_RST;
    endcase
  endfunction
  function automatic logic [7:0] model_vec();
    return mk_out(m_phase != P_RST && m_phase != P_START, m_phase == P_PLAY,
                  m_phase == P_HOLD && m_left == 1, m_phase == P_OVER, m_phase == P_WIN, m_lives, m_level);
  endfunction
  task automatic chk(string name, logic [7:0] exp);
    logic [7:0] got;
    got = dut_vec();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {clr,en,rsp,go,win,lives,lvl}=%b required %b", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic set_in(bit st, bit pa, bit co, bit go);
    bus.SC_GAMEFLOW_startButton_InLow = st;
    bus.SC_GAMEFLOW_pauseButton_InLow = pa;
    bus.SC_GAMEFLOW_collision_InHigh  = co;
    bus.SC_GAMEFLOW_goal_InHigh       = go;
  endtask
  task automatic pulse_reset(string name);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk(name, mk_out(0, 0, 0, 0, 0, LIVES, 0));
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    set_in(1, 1, 0, 0);
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("reset_state", mk_out(0, 0, 0, 0, 0, 3, 0));
    @(posedge clk);
    #2 rst = 1'b0;
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,3,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0,3,0));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0,0,3,0));
    tbl.push_back(mk(1,1,1,0, 1,0,0,0,0,2,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,2,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,2,0));
    tbl.push_back(mk(1,1,0,0, 1,0,1,0,0,2,0));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0,0,2,0));
    tbl.push_back(mk(1,1,1,0, 1,0,0,0,0,1,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,1,0));
    tbl.push_back(mk(1,1,0,0, 1,0,1,0,0,1,0));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0,0,1,0));
    tbl.push_back(mk(1,1,1,0, 1,0,0,1,0,0,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0,0,3,0));
    tbl.push_back(mk(1,1,0,1, 1,0,0,0,0,3,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,3,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,3,1));
    tbl.push_back(mk(1,1,0,0, 1,0,1,0,0,3,1));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0,0,3,1));
    tbl.push_back(mk(1,1,0,1, 1,0,0,0,1,3,1));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,1,3,1));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0,3,1));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0,0,3,0));
    tbl.push_back(mk(1,1,1,1, 1,0,0,0,0,2,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,2,0));
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0,2,0));
    tbl.push_back(mk(1,1,0,0, 1,0,1,0,0,2,0));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0,0,2,0));
    tbl.push_back(mk(1,0,0,0, 1,0,0,0,0,2,0));
    tbl.push_back(mk(1,1,1,1, 1,0,0,0,0,2,0));
    tbl.push_back(mk(1,0,0,0, 1,1,0,0,0,2,0));
    tbl.push_back(mk(1,1,0,0, 1,1,0,0,0,2,0));
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].st, tbl[i].pa, tbl[i].co, tbl[i].go);
      step();
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    set_in(1, 1, 1, 0);
    step();
    set_in(1, 1, 0, 0);
    step();
    step();
    chk("hit_timer2", mk_out(1, 0, 0, 0, 0, 1, 0));
    set_in(0, 1, 0, 0);
    pulse_reset("async_reset_mid_hit");
    step();
    chk("held_start_idle0", mk_out(1, 0, 0, 0, 0, 3, 0));
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("held_start_idle%0d", i), mk_out(1, 0, 0, 0, 0, 3, 0));
    end
    set_in(1, 1, 0, 0);
    step();
    chk("released_idle", mk_out(1, 0, 0, 0, 0, 3, 0));
    set_in(0, 1, 0, 0);
    step();
    chk("repress_start", mk_out(0, 0, 0, 0, 0, 3, 0));
    set_in(1, 1, 0, 0);
    step();
    chk("repress_play", mk_out(1, 1, 0, 0, 0, 3, 0));
    for (int c = 0; c < 4000; c++) begin
      set_in($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) pulse_reset($sformatf("rand_reset%0d", c));
      step();
      chk($sformatf("rand%0d", c), model_vec());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sc_gameflow_fsm.md
# sc_gameflow_fsm

Parametrised top-level game-flow controller for the Frogger playfield. It sequences reset, idle, start, play, pause, death, level-up, game-over and win phases. It tracks remaining lives and the current level, and drives the clear/enable/respawn strobes consumed by the playfield, lane and score blocks. It sits directly under the board top level and is clocked from CLOCK_50.

## Interface
- LIVES, 3: lives loaded at game start (≥1)
- LEVELS, 4: number of levels; clearing level LEVELS-1 wins (≥1)
- PAUSE_CYCLES, 50000000: length of the death/level-up hold in clocks (≥1; 1 s at 50 MHz)
- LIVES_W, $clog2(LIVES+1): lives counter width
- LEVEL_W, $clog2(LEVELS) (min 1): level counter width

Ports:
- SC_GAMEFLOW_CLOCK_50  in  1  system clock, rising edge
- SC_GAMEFLOW_RESET_InHigh  in  1  asynchronous reset, active-high
- SC_GAMEFLOW_startButton_InLow  in  1  start button, debounced, active-low
- SC_GAMEFLOW_pauseButton_InLow  in  1  pause button, debounced, active-low
- SC_GAMEFLOW_collision_InHigh  in  1  frog hit / drowned, level-sensitive
- SC_GAMEFLOW_goal_InHigh  in  1  frog reached home row, level-sensitive
- SC_GAMEFLOW_clear_OutLow  out  1  playfield clear, active-low
- SC_GAMEFLOW_enable_OutHigh  out  1  game logic running
- SC_GAMEFLOW_respawn_OutHigh  out  1  one-cycle frog respawn strobe
- SC_GAMEFLOW_gameOver_OutHigh  out  1  game-over indicator
- SC_GAMEFLOW_win_OutHigh  out  1  win indicator
- SC_GAMEFLOW_lives_Out  out  LIVES_W  remaining lives
- SC_GAMEFLOW_level_Out  out  LEVEL_W  current level, 0-based

## Operation
- Register set: 4-bit state register, lives counter, level counter, hold timer ($clog2(PAUSE_CYCLES+1) bits), and one previous-sample register per button.
- Button press: previous sample = 1 and current input = 0 at a clock edge. Previous-sample registers reset to 1.
- Reset values: state RESET, lives = LIVES, level = 0, timer = 0.
- Outputs decode combinationally from the state register. lives_Out and level_Out are the counter registers.
- States, outputs, and transitions:
  - RESET: clear_OutLow = 0, all else 0. Goes to IDLE unconditionally.
  - IDLE: clear_OutLow = 1, all strobes 0. Start press goes to START.
  - START: clear_OutLow = 0 for exactly one cycle. lives ← LIVES, level ← 0, timer ← 0. Goes to PLAY.
  - PLAY: enable_OutHigh = 1. Events are evaluated in this priority order:
    - collision with lives == 1: lives ← 0, go to GAMEOVER.
    - collision with lives > 1: lives ← lives-1, go to HIT.
    - goal with level == LEVELS-1: go to WIN.
    - goal otherwise: level ← level+1, go to LEVELUP.
    - pause press: go to PAUSED.
  - PAUSED: enable_OutHigh = 0. Pause press returns to PLAY. collision and goal are ignored.
  - HIT and LEVELUP: enable_OutHigh = 0. The timer increments each cycle. When timer == PAUSE_CYCLES-1, respawn_OutHigh = 1 for that cycle, timer ← 0, and the state returns to PLAY.
  - GAMEOVER: gameOver_OutHigh = 1, lives_Out = 0. Start press goes to START.
  - WIN: win_OutHigh = 1. Start press goes to START.
- Simultaneous events: collision beats goal; both beat pause.
- A start press outside IDLE, GAMEOVER and WIN is ignored. A pause press outside PLAY and PAUSED is ignored.
- Illegal state encodings go to RESET on the next edge.
- Reset mid-operation: immediate return to reset values, independent of clock. A held button does not generate a press after reset release until it is released and pressed again.

## Timing
- Every event is acted on at the clock edge where it is sampled. The new state and outputs are visible immediately after that edge, a latency of 1 clock.
- After reset release: 1 cycle in RESET (clear low), then IDLE.
- From start press to PLAY: 2 edges (START for 1 cycle, clear low 1 cycle).
- HIT/LEVELUP dwell is exactly PAUSE_CYCLES cycles. respawn_OutHigh is high in the last of these cycles only, and enable_OutHigh is high on the following cycle.
- Level-sensitive collision/goal held high re-triggers only once PLAY is re-entered.

## Test plan
Bench parameters: LIVES=3, LEVELS=2, PAUSE_CYCLES=4.
- Reset then start press: clear_OutLow is low 1 cycle (RESET), then high in IDLE. After the press, clear_OutLow is low 1 cycle, then enable=1, lives_Out=3, level_Out=0.
- Collision pulse in PLAY: lives_Out=2 and enable=0 for 4 cycles, respawn=1 in the 4th, enable=1 on the 5th. Repeat collisions: lives=1, then gameOver=1 with lives_Out=0 and no respawn.
- Goal in PLAY at level 0: level_Out=1, 4-cycle hold, respawn. Second goal: win=1. Start press in WIN: START, then lives=3, level=0.
- Collision and goal asserted in the same cycle: lives decrements, level unchanged, state HIT.
- Pause press in PLAY: enable=0. Collision during PAUSED produces no change. Second pause press: enable=1.
- Reset asserted mid-HIT (timer=2) with the start button held low: outputs return to reset values asynchronously. After release, IDLE persists until the button goes high and low again.
